// File: rtl/pc_unit.sv
// Fetch-stage program counter with sequential step, redirects, trap entry/return
// and a circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter bit              C_EXT        = 1'b0,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            compressed,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call_valid,
  input  logic            ret_valid,
  input  logic            trap,
  input  logic            trap_return,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_next_seq,
  output logic [XLEN-1:0] epc,
  output logic            misalign_fault,
  output logic            ras_empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_TRAP,
    ACT_TRET,
    ACT_JUMP,
    ACT_FAULT,
    ACT_RET,
    ACT_STEP
  } action_e;

  action_e          action;
  logic [XLEN-1:0]  step;
  logic             target_misaligned;
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] ras_count;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];

  always_comb begin
    step              = (C_EXT && compressed) ? XLEN'(2) : XLEN'(4);
    pc_next_seq       = pc + step;
    target_misaligned = C_EXT ? redirect_target[0] : (redirect_target[1:0] != 2'b00);
    top_idx           = ras_ptr - PTR_W'(1);
    ras_empty         = (ras_count == '0);
  end

  // One action per edge, highest priority first; a pending fault blocks all but trap.
  always_comb begin
    action = ACT_HOLD;
    if (trap)                           action = ACT_TRAP;
    else if (misalign_fault)            action = ACT_HOLD;
    else if (trap_return)               action = ACT_TRET;
    else if (redirect_valid)            action = target_misaligned ? ACT_FAULT : ACT_JUMP;
    else if (ret_valid && !ras_empty)   action = ACT_RET;
    else if (fetch_ready && pc_valid)   action = ACT_STEP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc             <= RESET_VECTOR;
      pc_valid       <= 1'b0;
      epc            <= '0;
      misalign_fault <= 1'b0;
      ras_ptr        <= '0;
      ras_count      <= '0;
    end else begin
      pc_valid <= !misalign_fault;
      unique case (action)
        ACT_TRAP: begin
          // Entering from a fault keeps the faulting target in epc so mret returns to it.
          if (!misalign_fault) epc <= pc;
          pc             <= TRAP_VECTOR;
          misalign_fault <= 1'b0;
          pc_valid       <= 1'b1;
        end
        ACT_TRET: pc <= epc;
        ACT_JUMP: begin
          pc <= redirect_target;
          if (call_valid) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_count != CNT_W'(RAS_DEPTH)) ras_count <= ras_count + CNT_W'(1);
          end
        end
        ACT_FAULT: begin
          misalign_fault <= 1'b1;
          epc            <= redirect_target;
          pc_valid       <= 1'b0;
        end
        ACT_RET: begin
          pc        <= ras_mem[top_idx];
          ras_ptr   <= top_idx;
          ras_count <= ras_count - CNT_W'(1);
        end
        ACT_STEP: pc <= pc_next_seq;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when the count says they were written.
  always_ff @(posedge clk) begin
    if (action == ACT_JUMP && call_valid) ras_mem[ras_ptr] <= pc_next_seq;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table on two instances
// (C_EXT=0 and C_EXT=1), async-reset sequences, and randomized model comparison.
module tb_pc_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_ready = 1'b0, compressed = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        call_valid = 1'b0, ret_valid = 1'b0, trap = 1'b0, trap_return = 1'b0;

  logic [31:0] pc0, nseq0, epc0, pc1, nseq1, epc1;
  logic        valid0, fault0, empty0, valid1, fault1, empty1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .C_EXT(1'b0), .RAS_DEPTH(DEPTH)) u0 (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .compressed(compressed),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .call_valid(call_valid), .ret_valid(ret_valid), .trap(trap), .trap_return(trap_return),
    .pc(pc0), .pc_valid(valid0), .pc_next_seq(nseq0), .epc(epc0),
    .misalign_fault(fault0), .ras_empty(empty0));

  pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .C_EXT(1'b1), .RAS_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .compressed(compressed),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .call_valid(call_valid), .ret_valid(ret_valid), .trap(trap), .trap_return(trap_return),
    .pc(pc1), .pc_valid(valid1), .pc_next_seq(nseq1), .epc(epc1),
    .misalign_fault(fault1), .ras_empty(empty1));

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        fr, cmp, rv;
    logic [31:0] tgt;
    logic        call, ret, trp, tret;
    logic [31:0] e_pc0, e_pc1;
    logic        e_valid0, e_fault0, e_empty0;
    logic [31:0] e_epc0;
  } vec_t;

  vec_t vt [32];

  task automatic drive(input logic fr, cmp, rv, input logic [31:0] tgt,
                       input logic call, ret, trp, tret);
    fetch_ready = fr; compressed = cmp; redirect_valid = rv; redirect_target = tgt;
    call_valid = call; ret_valid = ret; trap = trp; trap_return = tret;
  endtask

  // Behavioural reference: index 0 models C_EXT=0, index 1 models C_EXT=1.
  logic [31:0] m_pc [2], m_epc [2];
  logic        m_valid [2], m_fault [2];
  logic [31:0] rq0 [$], rq1 [$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = RV; m_epc[k] = '0; m_valid[k] = 1'b0; m_fault[k] = 1'b0;
    end
    rq0.delete(); rq1.delete();
  endtask

  function automatic int ras_size(input int k);
    return (k == 0) ? rq0.size() : rq1.size();
  endfunction

  task automatic ras_push(input int k, input logic [31:0] v);
    if (k == 0) begin rq0.push_back(v); if (rq0.size() > DEPTH) void'(rq0.pop_front()); end
    else        begin rq1.push_back(v); if (rq1.size() > DEPTH) void'(rq1.pop_front()); end
  endtask

  task automatic ras_pop(input int k, output logic [31:0] v);
    if (k == 0) v = rq0.pop_back();
    else        v = rq1.pop_back();
  endtask

  function automatic logic [31:0] seq_of(input int k, input logic [31:0] p, input logic cmp);
    return p + ((k == 1 && cmp) ? 32'd2 : 32'd4);
  endfunction

  task automatic model_step(input int k);
    logic [31:0] seq, v;
    logic        mis;
    seq = seq_of(k, m_pc[k], compressed);
    mis = (k == 1) ? redirect_target[0] : (redirect_target[1:0] != 2'b00);
    if (trap) begin
      if (!m_fault[k]) m_epc[k] = m_pc[k];
      m_pc[k] = TV; m_fault[k] = 1'b0;
    end else if (m_fault[k]) begin
    end else if (trap_return) begin
      m_pc[k] = m_epc[k];
    end else if (redirect_valid) begin
      if (mis) begin m_fault[k] = 1'b1; m_epc[k] = redirect_target; end
      else begin
        if (call_valid) ras_push(k, seq);
        m_pc[k] = redirect_target;
      end
    end else if (ret_valid && ras_size(k) > 0) begin
      ras_pop(k, v); m_pc[k] = v;
    end else if (fetch_ready && m_valid[k]) begin
      m_pc[k] = seq;
    end
    m_valid[k] = !m_fault[k];
  endtask

  task automatic model_cmp(input int idx);
    logic [98:0] act0, act1, exp0, exp1;
    act0 = {pc0, valid0, epc0, fault0, empty0, nseq0};
    act1 = {pc1, valid1, epc1, fault1, empty1, nseq1};
    exp0 = {m_pc[0], m_valid[0], m_epc[0], m_fault[0], ras_size(0) == 0, seq_of(0, m_pc[0], compressed)};
    exp1 = {m_pc[1], m_valid[1], m_epc[1], m_fault[1], ras_size(1) == 0, seq_of(1, m_pc[1], compressed)};
    tests += 2;
    if (act0 !== exp0) begin fails++; $display("FAIL rand_c0 [%0d]: got %h, want %h", idx, act0, exp0); end
    if (act1 !== exp1) begin fails++; $display("FAIL rand_c1 [%0d]: got %h, want %h", idx, act1, exp1); end
  endtask

  initial begin
    //          fr cmp rv tgt           call ret trp tret  pc0           pc1           v  f  e  epc0
    vt[0]  = '{1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 32'h0};
    vt[1]  = '{1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h4,        32'h4,        1, 0, 1, 32'h0};
    vt[2]  = '{1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h8,        32'h8,        1, 0, 1, 32'h0};
    vt[3]  = '{1, 0, 0, 32'h0,        0, 0, 0, 0, 32'hC,        32'hC,        1, 0, 1, 32'h0};
    vt[4]  = '{0, 0, 0, 32'h0,        0, 0, 0, 0, 32'hC,        32'hC,        1, 0, 1, 32'h0};
    vt[5]  = '{0, 0, 0, 32'h0,        0, 0, 0, 0, 32'hC,        32'hC,        1, 0, 1, 32'h0};
    vt[6]  = '{0, 0, 1, 32'h10,       0, 0, 0, 0, 32'h10,       32'h10,       1, 0, 1, 32'h0};
    vt[7]  = '{1, 1, 0, 32'h0,        0, 0, 0, 0, 32'h14,       32'h12,       1, 0, 1, 32'h0};
    vt[8]  = '{1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h18,       32'h16,       1, 0, 1, 32'h0};
    vt[9]  = '{0, 0, 1, 32'h20,       0, 0, 0, 0, 32'h20,       32'h20,       1, 0, 1, 32'h0};
    vt[10] = '{0, 0, 1, 32'h80,       1, 0, 0, 0, 32'h80,       32'h80,       1, 0, 0, 32'h0};
    vt[11] = '{0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h24,       32'h24,       1, 0, 1, 32'h0};
    vt[12] = '{1, 0, 0, 32'h0,        0, 1, 0, 0, 32'h28,       32'h28,       1, 0, 1, 32'h0};
    vt[13] = '{0, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 32'h0};
    vt[14] = '{0, 0, 1, 32'h4,        1, 0, 0, 0, 32'h4,        32'h4,        1, 0, 0, 32'h0};
    vt[15] = '{0, 0, 1, 32'h8,        1, 0, 0, 0, 32'h8,        32'h8,        1, 0, 0, 32'h0};
    vt[16] = '{0, 0, 1, 32'hC,        1, 0, 0, 0, 32'hC,        32'hC,        1, 0, 0, 32'h0};
    vt[17] = '{0, 0, 1, 32'h10,       1, 0, 0, 0, 32'h10,       32'h10,       1, 0, 0, 32'h0};
    vt[18] = '{0, 0, 1, 32'h14,       1, 0, 0, 0, 32'h14,       32'h14,       1, 0, 0, 32'h0};
    vt[19] = '{0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h14,       32'h14,       1, 0, 0, 32'h0};
    vt[20] = '{0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h10,       32'h10,       1, 0, 0, 32'h0};
    vt[21] = '{0, 0, 0, 32'h0,        0, 1, 0, 0, 32'hC,        32'hC,        1, 0, 0, 32'h0};
    vt[22] = '{0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h8,        32'h8,        1, 0, 1, 32'h0};
    vt[23] = '{1, 0, 0, 32'h0,        0, 1, 0, 0, 32'hC,        32'hC,        1, 0, 1, 32'h0};
    vt[24] = '{0, 0, 1, 32'h102,      0, 0, 0, 0, 32'hC,        32'h102,      0, 1, 1, 32'h102};
    vt[25] = '{1, 0, 1, 32'h200,      0, 0, 0, 0, 32'hC,        32'h200,      0, 1, 1, 32'h102};
    vt[26] = '{0, 0, 0, 32'h0,        0, 0, 1, 0, 32'h100,      32'h100,      1, 0, 1, 32'h102};
    vt[27] = '{0, 0, 0, 32'h0,        0, 0, 0, 1, 32'h102,      32'h200,      1, 0, 1, 32'h102};
    vt[28] = '{0, 0, 1, 32'h40,       0, 0, 0, 0, 32'h40,       32'h40,       1, 0, 1, 32'h102};
    vt[29] = '{0, 0, 1, 32'h80,       0, 0, 1, 0, 32'h100,      32'h100,      1, 0, 1, 32'h40};
    vt[30] = '{0, 0, 1, 32'hFFFF_FFFC,0, 0, 0, 0, 32'hFFFF_FFFC,32'hFFFF_FFFC,1, 0, 1, 32'h40};
    vt[31] = '{1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 32'h40};

    // Reset state while held in reset
    #12;
    chk("rst_pc", 0, pc0, RV);
    chk("rst_valid", 0, 32'(valid0), 32'd0);
    chk("rst_epc", 0, epc0, 32'h0);
    chk("rst_fault", 0, 32'(fault0), 32'd0);
    chk("rst_empty", 0, 32'(empty0), 32'd1);
    chk("rst_nseq", 0, nseq0, 32'h4);
    @(negedge clk); rst = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].fr, vt[i].cmp, vt[i].rv, vt[i].tgt, vt[i].call, vt[i].ret, vt[i].trp, vt[i].tret);
      @(posedge clk); #1;
      chk("pc_c0", i, pc0, vt[i].e_pc0);
      chk("pc_c1", i, pc1, vt[i].e_pc1);
      chk("valid", i, 32'(valid0), 32'(vt[i].e_valid0));
      chk("fault", i, 32'(fault0), 32'(vt[i].e_fault0));
      chk("empty", i, 32'(empty0), 32'(vt[i].e_empty0));
      chk("epc", i, epc0, vt[i].e_epc0);
    end

    // Asynchronous reset mid-stall, between clock edges
    drive(0, 0, 1, 32'h50, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("pre_areset_pc", 0, pc0, 32'h50);
    drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
    #3 rst = 1'b0;
    #1;
    chk("areset_pc_c0", 0, pc0, RV);
    chk("areset_pc_c1", 0, pc1, RV);
    chk("areset_valid", 0, 32'(valid0), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Asynchronous reset clears a pending misalign fault
    drive(0, 0, 1, 32'h103, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("fault_set_c0", 0, 32'(fault0), 32'd1);
    chk("fault_set_c1", 0, 32'(fault1), 32'd1);
    drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("fault_clr_c0", 0, 32'(fault0), 32'd0);
    chk("fault_clr_c1", 0, 32'(fault1), 32'd0);
    chk("fault_clr_epc", 0, epc0, 32'h0);

    // Randomized run against the reference model
    model_reset();
    @(negedge clk); rst = 1'b1;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] t;
      t = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, t,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0);
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      model_cmp(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
